dst_ctrl: RTL and testbench
===========================

# dst_ctrl

Result-drain stage directly downstream of the compute-completion control. Captures the result words written by the output register file into a bank buffer, commits the bank on the `s_fin_in` pulse, and streams it out as an AXI-Stream master packet of exactly `WORDS` beats toward the DMA. Drives `dst_ready` back upstream so `s_fin_in` is only ever raised when a bank is free.

## Interface
- `DATA_W`, 32, result word width
- `WORDS`, 64, words per result block (power of two, ≥2)
- `clk` in 1: sole clock
- `rst_n` in 1: asynchronous, active-low reset
- `run` in 1: low = synchronous clear of all state (same values as reset)
- `wr_en` in 1: write one result word into the current fill bank
- `wr_addr` in $clog2(WORDS): word index within the block
- `wr_data` in DATA_W: result word
- `s_fin_in` in 1: single-cycle commit of the fill bank
- `dst_ready` out 1: fill bank empty; commit is accepted
- `m_valid` out 1, `m_data` out DATA_W, `m_last` out 1, `m_ready` in 1: output stream
- `busy` out 1: any bank full or beat outstanding

## Operation
- Per-bank `full` flag; fill pointer `wp`, drain pointer `rp` (1 bit each with ping-pong, constant 0 without).
- `dst_ready = ~full[wp]`, from registers only; no combinational path from `m_ready`.
- `wr_en` while `full[wp]`: write dropped. `s_fin_in` while `~dst_ready`: ignored; simulation assertion fires.
- Commit: sets `full[wp]`, toggles `wp`.
- Drain FSM states IDLE, STREAM.
  - IDLE: if `full[rp]`, issue read of word 0 and go to STREAM.
  - STREAM: issue the next read whenever `~m_valid | m_ready` and words remain. The RAM output register is `m_data`, enabled by the read issue. `m_valid` is set on issue and cleared on handshake with no issue.
  - `m_last` is high with word `WORDS-1`.
- Last handshake (`m_valid & m_ready & m_last`): clear `full[rp]` and toggle `rp`. If the other bank is already full, issue its word 0 in the same cycle and stay in STREAM with no bubble. Otherwise go to IDLE.
- Beat counter is `$clog2(WORDS)+1` bits and never wraps past `WORDS`.
- `run` low mid-packet: the packet is aborted without `m_last`, `m_valid` drops the next cycle, and all banks become empty.
- Reset and run-low values:
  - `full`=0, `wp`=`rp`=0
  - `m_valid`=0, `m_data`=0, `m_last`=0
  - `busy`=0, `dst_ready`=1
  - state IDLE

## Timing
- Write: 1-cycle synchronous RAM write.
- `s_fin_in` high in cycle 0:
  - `full` is set and `dst_ready` (single bank) drops in cycle 1.
  - Word 0 read is issued in cycle 1.
  - `m_valid` is asserted with word 0 in cycle 2.
- With `m_ready` held high: 1 beat per cycle, `WORDS` consecutive cycles.
- `m_data`/`m_last` are held stable while `m_valid & ~m_ready`.
- Last handshake in cycle k: the released bank shows `dst_ready`=1 in cycle k+1.
- Commit and release in the same cycle (ping-pong, different banks): both take effect.

## Configuration
- `DST_PINGPONG_EN` defined: two banks. Upstream may fill and commit bank B while bank A streams. `dst_ready` stays high unless both banks are full.
- Not defined: one bank. `dst_ready` is low from the cycle after commit until the cycle after the last handshake. Pointers are tied to 0.

## Structure
- Shared package `hpu_pkg`: `DATA_W`/`WORDS` defaults and the `dst_state_t` enum (IDLE, STREAM).
- Sub-module `dst_bank_ram`: simple dual-port RAM, `WORDS`×`DATA_W`, 1-cycle registered read with read-enable. One instance per bank.
- `dst_ctrl` holds the flags, pointers, FSM and beat counter.

## Test plan
Bench uses `WORDS`=4, `DATA_W`=32.
- Write 0x10–0x13, commit, `m_ready`=1 → beats 0x10, 0x11, 0x12, 0x13 in cycles 2–5 after commit; `m_last` only on 0x13; `dst_ready` back to 1 in cycle 6.
- Same stimulus with `m_ready` toggling 1/0 → identical data order; `m_data` stable during stalls; exactly 4 handshakes.
- Ping-pong: commit A (0xA0–0xA3), commit B (0xB0–0xB3) during A's stream → 8 gap-free beats; `m_last` on 0xA3 and 0xB3; `dst_ready` low only while both banks are full.
- Single bank: commit, then `wr_en` + `s_fin_in` while `dst_ready`=0 → writes dropped, assertion fires, streamed data unchanged.
- Drop `run` after 2 beats → `m_valid`=0 the next cycle, `dst_ready`=1, `busy`=0; a new block then streams from word 0.
- Assert `rst_n` low mid-stream, asynchronously → all outputs at reset values immediately.

Source files
------------

// File: rtl/hpu_pkg.sv
// Shared HPU definitions: default result-block geometry and the drain FSM state type.
package hpu_pkg;

   localparam int HPU_DATA_W = 32;
   localparam int HPU_WORDS  = 64;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } dst_state_t;

endpackage

// File: rtl/dst_ctrl_if.sv
// Result-drain bus: write port from the output register file, commit/ready pair,
// and the outgoing stream toward the DMA. The drain block uses the master modport.
interface dst_ctrl_if
   import hpu_pkg::*;
#(
   parameter int DATA_W = HPU_DATA_W,
   parameter int WORDS  = HPU_WORDS
);

   logic                     wr_en;
   logic [$clog2(WORDS)-1:0] wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     s_fin_in;
   logic                     dst_ready;
   logic                     m_valid;
   logic [DATA_W-1:0]        m_data;
   logic                     m_last;
   logic                     m_ready;

   modport master (
      input  wr_en, wr_addr, wr_data, s_fin_in, m_ready,
      output dst_ready, m_valid, m_data, m_last
   );

   modport slave (
      output wr_en, wr_addr, wr_data, s_fin_in, m_ready,
      input  dst_ready, m_valid, m_data, m_last
   );

endinterface

// File: rtl/dst_bank_ram.sv
// One result bank: WORDS x DATA_W simple dual-port RAM, synchronous write,
// registered read with read enable. The read register doubles as the stream data register.
module dst_bank_ram
   import hpu_pkg::*;
#(
   parameter int DATA_W = HPU_DATA_W,
   parameter int WORDS  = HPU_WORDS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     we,
   input  logic [$clog2(WORDS)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     re,
   input  logic [$clog2(WORDS)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [WORDS];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Only the output register is cleared; array contents are don't-care until rewritten.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      rdata <= '0;
      else if (clr)    rdata <= '0;
      else if (re)     rdata <= mem[raddr];
   end

endmodule

// File: rtl/dst_ctrl.sv
// Result-drain stage: captures result words into a bank, commits on s_fin_in, streams
// the bank out as a WORDS-beat packet. DST_PINGPONG_EN selects two banks instead of one.
module dst_ctrl
   import hpu_pkg::*;
#(
   parameter int DATA_W = HPU_DATA_W,
   parameter int WORDS  = HPU_WORDS
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      run,
   dst_ctrl_if.master bus,
   output logic      busy
);

   localparam int AW = $clog2(WORDS);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] END_CNT   = CW'(WORDS);
   localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);
`ifdef DST_PINGPONG_EN
   localparam logic PP = 1'b1;
`else
   localparam logic PP = 1'b0;
`endif

   dst_state_t        state_q, state_d;
   logic [1:0]        full_q, full_d;
   logic              wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              vld_p1, vld_d;
   logic              last_p1, last_d;
   logic              issue, issue_bank;
   logic [AW-1:0]     issue_addr;
   logic              hs, last_hs, commit, wr_ok;
   logic [DATA_W-1:0] rdata0;

   assign hs      = vld_p1 & bus.m_ready;
   assign last_hs = hs & last_p1;
   assign commit  = bus.s_fin_in & ~full_q[wp_q];
   assign wr_ok   = bus.wr_en & ~full_q[wp_q];

   always_comb begin
      state_d    = state_q;
      full_d     = full_q;
      wp_d       = wp_q;
      rp_d       = rp_q;
      cnt_d      = cnt_q;
      vld_d      = vld_p1;
      last_d     = last_p1;
      issue      = 1'b0;
      issue_bank = rp_q;
      issue_addr = '0;

      unique case (state_q)
         IDLE: begin
            if (full_q[rp_q]) begin
               issue   = 1'b1;
               cnt_d   = CW'(1);
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (last_hs) begin
               full_d[rp_q] = 1'b0;
               rp_d         = rp_q ^ PP;
               // Chain straight into the other bank when it is already waiting.
               if (PP && full_q[~rp_q]) begin
                  issue      = 1'b1;
                  issue_bank = ~rp_q;
                  cnt_d      = CW'(1);
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end else if ((~vld_p1 | bus.m_ready) && cnt_q != END_CNT) begin
               issue      = 1'b1;
               issue_addr = cnt_q[AW-1:0];
               cnt_d      = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (commit) begin
         full_d[wp_q] = 1'b1;
         wp_d         = wp_q ^ PP;
      end

      if (issue) begin
         vld_d  = 1'b1;
         last_d = (issue_addr == LAST_ADDR);
      end else if (hs) begin
         vld_d  = 1'b0;
         last_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         full_q  <= '0;
         wp_q    <= 1'b0;
         rp_q    <= 1'b0;
         cnt_q   <= '0;
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else if (!run) begin
         state_q <= IDLE;
         full_q  <= '0;
         wp_q    <= 1'b0;
         rp_q    <= 1'b0;
         cnt_q   <= '0;
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else begin
         state_q <= state_d;
         full_q  <= full_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
         vld_p1  <= vld_d;
         last_p1 <= last_d;
      end
   end

   // Stage p1: bank read registers carry the beat presented on m_data.
   dst_bank_ram #(.DATA_W(DATA_W), .WORDS(WORDS)) u_bank0 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (~run),
      .we    (wr_ok & ~wp_q),
      .waddr (bus.wr_addr),
      .wdata (bus.wr_data),
      .re    (issue & ~issue_bank),
      .raddr (issue_addr),
      .rdata (rdata0)
   );

`ifdef DST_PINGPONG_EN
   logic [DATA_W-1:0] rdata1;
   logic              sel_p1;

   dst_bank_ram #(.DATA_W(DATA_W), .WORDS(WORDS)) u_bank1 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (~run),
      .we    (wr_ok & wp_q),
      .waddr (bus.wr_addr),
      .wdata (bus.wr_data),
      .re    (issue & issue_bank),
      .raddr (issue_addr),
      .rdata (rdata1)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     sel_p1 <= 1'b0;
      else if (!run)  sel_p1 <= 1'b0;
      else if (issue) sel_p1 <= issue_bank;
   end

   assign bus.m_data = sel_p1 ? rdata1 : rdata0;
`else
   assign bus.m_data = rdata0;
`endif

   assign bus.dst_ready = ~full_q[wp_q];
   assign bus.m_valid   = vld_p1;
   assign bus.m_last    = last_p1;
   assign busy          = (|full_q) | vld_p1;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n && run && bus.s_fin_in)
         assert (bus.dst_ready)
         else $warning("dst_ctrl: s_fin_in raised while dst_ready low; commit ignored");
   end
`endif

endmodule

// File: tb/tb_dst_ctrl.sv
// Scoreboard bench for dst_ctrl (WORDS=4, DATA_W=32); adapts to DST_PINGPONG_EN.
module tb_dst_ctrl;

   localparam int DW = 32;
   localparam int W  = 4;
   localparam int AW = 2;
`ifdef DST_PINGPONG_EN
   localparam int NB = 2;
`else
   localparam int NB = 1;
`endif

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;
   logic run;
   logic busy;

   dst_ctrl_if #(.DATA_W(DW), .WORDS(W)) bus ();

   dst_ctrl #(.DATA_W(DW), .WORDS(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (run),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int hs_cnt = 0;
   int pend   = 0;
   int rmode  = 0;
   beat_t exp_q[$];
   logic [DW-1:0] blk [W];

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
      end
   endfunction

   // m_ready patterns: 0 always high, 1 toggling, 2 random (75% high), 3 held low
   always @(posedge clk) begin
      #1;
      case (rmode)
         0:       bus.m_ready = 1'b1;
         1:       bus.m_ready = ~bus.m_ready;
         2:       bus.m_ready = ($urandom_range(0, 3) != 0);
         default: bus.m_ready = 1'b0;
      endcase
   end

   // Monitor / reference model: pend = committed blocks not yet fully handed over.
   bit            stall_prev = 1'b0;
   bit            exp_vnext  = 1'b0;
   bit            rel;
   logic [DW-1:0] prev_d;
   logic          prev_l;
   beat_t         e;

   always @(negedge clk) begin
      if (!rst_n || !run) begin
         exp_q.delete();
         pend       = 0;
         stall_prev = 1'b0;
         exp_vnext  = 1'b0;
      end else begin
         rel = 1'b0;
         check("dst_ready", bus.dst_ready, pend < NB);
         check("busy", busy, pend != 0);
         if (exp_vnext) check("no_bubble", bus.m_valid, 1);
         if (stall_prev) begin
            check("hold_valid", bus.m_valid, 1);
            check("hold_data", bus.m_data, prev_d);
            check("hold_last", bus.m_last, prev_l);
         end
         exp_vnext = 1'b0;
         if (bus.m_valid && bus.m_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_beat: actual 0x%0h required no beat", bus.m_data);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", bus.m_data, e.d);
               check("beat_last", bus.m_last, e.l);
               rel       = e.l;
               exp_vnext = !e.l || pend >= 2;
            end
         end
         stall_prev = bus.m_valid && !bus.m_ready;
         prev_d     = bus.m_data;
         prev_l     = bus.m_last;
         if (bus.s_fin_in && pend < NB) pend++;
         if (rel) pend--;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_block(input bit gaps);
      int    t;
      beat_t nb;
      t = 0;
      // Stray writes while no bank is free must be dropped.
      while (!bus.dst_ready && t < 300) begin
         bus.wr_en   = 1'($urandom_range(0, 1));
         bus.wr_addr = AW'($urandom_range(0, W - 1));
         bus.wr_data = $urandom;
         cyc();
         t++;
      end
      bus.wr_en = 1'b0;
      if (t >= 300) begin
         n_chk++;
         n_fail++;
         $display("FAIL ready_timeout: dst_ready 0 after %0d cycles, required 1", t);
         return;
      end
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'($urandom_range(0, W - 1));
      bus.wr_data = $urandom;
      cyc();
      for (int i = 0; i < W; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            bus.wr_en = 1'b0;
            cyc();
         end
         bus.wr_en   = 1'b1;
         bus.wr_addr = AW'(i);
         bus.wr_data = blk[i];
         cyc();
      end
      bus.wr_en    = 1'b0;
      bus.s_fin_in = 1'b1;
      for (int i = 0; i < W; i++) begin
         nb.d = blk[i];
         nb.l = (i == W - 1);
         exp_q.push_back(nb);
      end
      cyc();
      bus.s_fin_in = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || busy) && t < 400) begin
         cyc();
         t++;
      end
      check("drain_left", exp_q.size(), 0);
   endtask

   task automatic fill_blk(input logic [DW-1:0] base, input bit rnd);
      for (int i = 0; i < W; i++) blk[i] = rnd ? DW'($urandom) : base + DW'(i);
   endtask

   initial begin
      int first, rdy, base, t;
      rst_n = 1'b0;
      run   = 1'b0;
      bus.wr_en    = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.s_fin_in = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", bus.m_valid, 0);
      check("rst_last", bus.m_last, 0);
      check("rst_data", bus.m_data, 0);
      check("rst_ready", bus.dst_ready, 1);
      check("rst_busy", busy, 0);
      cyc();
      rst_n = 1'b1;
      run   = 1'b1;
      cyc();

      // Latency: commit in cycle 0, first beat in cycle 2, bank released after beat 4
      rmode = 0;
      fill_blk(32'h10, 1'b0);
      send_block(1'b0);
      first = -1;
      rdy   = -1;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (first < 0 && bus.m_valid) first = n;
         if (rdy < 0 && bus.dst_ready) rdy = n;
         cyc();
      end
      check("first_beat_cycle", first, 2);
      check("ready_back_cycle", rdy, (NB == 1) ? 6 : 1);
      wait_idle();

      // Toggling m_ready: same data, exactly W handshakes
      rmode = 1;
      base  = hs_cnt;
      send_block(1'b0);
      wait_idle();
      check("toggle_beats", hs_cnt - base, W);

      // Stalled stream, stray writes while full, then two blocks back to back
      rmode = 3;
      fill_blk(32'hA0, 1'b0);
      send_block(1'b0);
`ifdef DST_PINGPONG_EN
      fill_blk(32'hB0, 1'b0);
      send_block(1'b0);
`endif
      for (int n = 0; n < 4; n++) begin
         bus.wr_en   = !bus.dst_ready;
         bus.wr_addr = AW'(n);
         bus.wr_data = 32'hDEAD0000 + n;
         cyc();
      end
      bus.wr_en = 1'b0;
      check("full_ready_low", bus.dst_ready, 0);
      rmode = 0;
`ifndef DST_PINGPONG_EN
      fill_blk(32'hB0, 1'b0);
      send_block(1'b0);
`endif
      wait_idle();

      // run low after two beats aborts the packet
      fill_blk(0, 1'b1);
      send_block(1'b0);
      base = hs_cnt;
      t    = 0;
      while (hs_cnt < base + 2 && t < 50) begin
         cyc();
         t++;
      end
      check("run_two_beats", hs_cnt - base, 2);
      run = 1'b0;
      cyc();
      run = 1'b1;
      @(negedge clk);
      check("run_valid", bus.m_valid, 0);
      check("run_ready", bus.dst_ready, 1);
      check("run_busy", busy, 0);
      cyc();
      fill_blk(0, 1'b1);
      send_block(1'b0);
      wait_idle();

      // Asynchronous reset mid-stream
      fill_blk(0, 1'b1);
      send_block(1'b0);
      base = hs_cnt;
      t    = 0;
      while (hs_cnt < base + 1 && t < 50) begin
         cyc();
         t++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", bus.m_valid, 0);
      check("arst_last", bus.m_last, 0);
      check("arst_data", bus.m_data, 0);
      check("arst_ready", bus.dst_ready, 1);
      check("arst_busy", busy, 0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // Random traffic under random backpressure
      rmode = 2;
      for (int b = 0; b < 10; b++) begin
         fill_blk(0, 1'b1);
         send_block(1'b1);
         repeat ($urandom_range(0, 3)) cyc();
      end
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
